// File: rtl/final_color_pkg.sv
// Shared definitions for the final color multiplexer: flash FSM state type,
// default screen geometry and the reserved color codes.
package final_color_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_e;

    localparam int DEFAULT_SCREEN_WIDTH  = 640;
    localparam int DEFAULT_SCREEN_HEIGHT = 480;
    localparam int DEFAULT_TRANSPARENT   = 7;
    localparam int DEFAULT_BLANK_COLOR   = 7;
    localparam int DEFAULT_BG_COLOR      = 0;

    // A position outside the visible area belongs to the blanking region.
    function automatic logic isBlank(input logic [9:0] h, input logic [9:0] v,
                                     input int width, input int height);
        return (int'({22'b0, h}) >= width) || (int'({22'b0, v}) >= height);
    endfunction

endpackage

// File: rtl/layer_priority_sel.sv
// Combinational priority picker: returns the color of the lowest-index layer
// that is not transparent, plus a flag telling whether any layer had a pixel.
module layer_priority_sel
    import final_color_pkg::*;
#(
    parameter int N_LAYERS    = 4,
    parameter int COLOR_W     = 3,
    parameter int TRANSPARENT = DEFAULT_TRANSPARENT
) (
    input  logic [N_LAYERS*COLOR_W-1:0] layers_i,
    output logic [COLOR_W-1:0]          color_o,
    output logic                        found_o
);

    // Scan from the lowest-priority layer upward so layer 0 is written last and wins.
    always_comb begin
        color_o = '0;
        found_o = 1'b0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layers_i[i*COLOR_W +: COLOR_W] != COLOR_W'(TRANSPARENT)) begin
                color_o = layers_i[i*COLOR_W +: COLOR_W];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/final_color_mux.sv
// Final pixel color stage: two-cycle pipeline that resolves layer priority,
// applies blanking and, when FINAL_COLOR_FLASH_EN is defined, a frame-based
// screen flash driven by a small IDLE/FLASH state machine.
module final_color_mux
    import final_color_pkg::*;
#(
    parameter int COLOR_W       = 3,
    parameter int N_LAYERS      = 4,
    parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter int TRANSPARENT   = DEFAULT_TRANSPARENT,
    parameter int BLANK_COLOR   = DEFAULT_BLANK_COLOR,
    parameter int BG_COLOR      = DEFAULT_BG_COLOR,
    parameter int FLASH_FRAMES  = 8,
    parameter int FLASH_COLOR   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [9:0]                  hPos,
    input  logic [9:0]                  vPos,
    input  logic                        valid_in,
    input  logic                        flash_req,
    output logic [COLOR_W-1:0]          color,
    output logic                        valid_out,
    output logic                        flash_active
);

    logic [COLOR_W-1:0] selColor;
    logic               selFound;
    logic [COLOR_W-1:0] s1Color_d;
    logic               s1Blank_d;
    logic [COLOR_W-1:0] s1Color_q;
    logic               s1Blank_q;
    logic               s1Valid_q;
    logic               flashFill;
    logic [COLOR_W-1:0] outColor_d;
    logic [COLOR_W-1:0] outColor_q;
    logic               outValid_q;

    layer_priority_sel #(
        .N_LAYERS    (N_LAYERS),
        .COLOR_W     (COLOR_W),
        .TRANSPARENT (TRANSPARENT)
    ) u_layer_priority_sel (
        .layers_i (layer_color),
        .color_o  (selColor),
        .found_o  (selFound)
    );

    // Stage 1 inputs: fall back to the background when every layer is empty.
    always_comb begin
        s1Color_d = selFound ? selColor : COLOR_W'(BG_COLOR);
        s1Blank_d = isBlank(hPos, vPos, SCREEN_WIDTH, SCREEN_HEIGHT);
    end

    // Stage 1 valid bit; reset drops any pixel in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
        end else begin
            s1Valid_q <= valid_in;
        end
    end

    // Stage 1 data only matters when its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        s1Color_q <= s1Color_d;
        s1Blank_q <= s1Blank_d;
    end

`ifdef FINAL_COLOR_FLASH_EN
    localparam int CNT_W = $clog2(FLASH_FRAMES) + 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FLASH_FRAMES - 1);

    flash_state_e     state_q;
    flash_state_e     state_d;
    logic [CNT_W-1:0] flashCnt_q;
    logic [CNT_W-1:0] flashCnt_d;
    logic             frameStart;

    assign frameStart = valid_in && (hPos == 10'd0) && (vPos == 10'd0);

    // Flash sequencing: a request always (re)starts at frame 0, otherwise count frame starts until the last one.
    always_comb begin
        state_d    = state_q;
        flashCnt_d = flashCnt_q;
        if (flash_req) begin
            state_d    = FLASH;
            flashCnt_d = '0;
        end else if ((state_q == FLASH) && frameStart) begin
            if (flashCnt_q == LAST_FRAME) begin
                state_d    = IDLE;
                flashCnt_d = '0;
            end else begin
                flashCnt_d = flashCnt_q + 1'b1;
            end
        end
    end

    // The state advances while the boundary pixel moves into stage 1, so that pixel already sees the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            flashCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            flashCnt_q <= flashCnt_d;
        end
    end

    assign flashFill    = (state_q == FLASH) && !flashCnt_q[0];
    assign flash_active = (state_q == FLASH);
`else
    logic unusedFlash;

    assign unusedFlash  = flash_req ^ (FLASH_FRAMES > 0);
    assign flashFill    = 1'b0;
    assign flash_active = 1'b0;
`endif

    // Stage 2 color: blanking overrides everything, then flash fill, then the layer result.
    always_comb begin
        if (s1Blank_q) begin
            outColor_d = COLOR_W'(BLANK_COLOR);
        end else if (flashFill) begin
            outColor_d = COLOR_W'(FLASH_COLOR);
        end else begin
            outColor_d = s1Color_q;
        end
    end

    // Output register holds the last valid pixel while no new pixel arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            outColor_q <= COLOR_W'(BLANK_COLOR);
            outValid_q <= 1'b0;
        end else begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outColor_q <= outColor_d;
            end
        end
    end

    assign color     = outColor_q;
    assign valid_out = outValid_q;

endmodule

// File: doc/final_color_mux.md
FINAL_COLOR_MUX -- requirements
Module: final_color_mux

Interface
REQ-001 Parameter COLOR_W, default 3: bits per pixel color.
REQ-002 Parameter N_LAYERS, default 4: number of sprite/background layer inputs; layer 0 has highest priority.
REQ-003 Parameter SCREEN_WIDTH, default 640: visible pixels per line.
REQ-004 Parameter SCREEN_HEIGHT, default 480: visible lines per frame.
REQ-005 Parameter TRANSPARENT, default 7: layer code meaning "no pixel here".
REQ-006 Parameters BLANK_COLOR, default 7, and BG_COLOR, default 0: blanking-region and empty-pixel colors.
REQ-007 Parameters FLASH_FRAMES, default 8, and FLASH_COLOR, default 4: flash duration in frames and flash fill color.
REQ-008 clk  input  1  single system clock, rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 layer_color  input  N_LAYERS*COLOR_W  packed layer colors; layer i occupies bits [i*COLOR_W +: COLOR_W].
REQ-011 hPos  input  10  horizontal pixel position for this cycle.
REQ-012 vPos  input  10  vertical line position for this cycle.
REQ-013 valid_in  input  1  qualifies layer_color/hPos/vPos.
REQ-014 flash_req  input  1  single-cycle request to start a screen flash (player hit).
REQ-015 color  output  COLOR_W  final pixel color.
REQ-016 valid_out  output  1  qualifies color; valid_in delayed by 2 cycles.
REQ-017 flash_active  output  1  high while the flash state machine is in FLASH.

Function
REQ-018 Latency SHALL be exactly 2 clocks from valid_in to valid_out; pipeline never stalls; one pixel per clock.
REQ-019 Stage 1 SHALL pick the lowest-index layer whose color != TRANSPARENT; if all are TRANSPARENT, it SHALL pick BG_COLOR.
REQ-020 A pixel SHALL be blanked when hPos >= SCREEN_WIDTH or vPos >= SCREEN_HEIGHT; color = BLANK_COLOR regardless of layers or flash.
REQ-021 Frame boundary SHALL be a cycle with valid_in=1, hPos=0, vPos=0.
REQ-022 Flash FSM states are IDLE and FLASH; IDLE->FLASH on flash_req, loading frame counter to 0.
REQ-023 In FLASH, the counter SHALL increment at each frame boundary; FLASH->IDLE at the boundary where counter reaches FLASH_FRAMES-1.
REQ-024 In FLASH, non-blank pixels SHALL be FLASH_COLOR when counter bit 0 = 0, and the normal layer result when bit 0 = 1.
REQ-025 flash_req in FLASH SHALL restart the counter at 0 (retrigger); flash_req coincident with the terminal frame boundary SHALL keep FLASH with counter 0.
REQ-026 The flash decision SHALL use the FSM state at stage 2, so the switch takes effect exactly at the first pixel of a frame boundary.
REQ-027 When valid_out=0, color SHALL hold its previous value.
REQ-028 Counter width SHALL be $clog2(FLASH_FRAMES)+1; FLASH_FRAMES=1 SHALL yield one all-flash frame.

Reset
REQ-029 On reset: color=BLANK_COLOR, valid_out=0, flash_active=0, FSM=IDLE, counter=0, all pipeline valids cleared.
REQ-030 Reset mid-flash or mid-line SHALL abort; in-flight pixels are discarded, with no output until new valid_in reaches stage 2.

Configuration
REQ-031 Macro FINAL_COLOR_FLASH_EN: defined -> FSM, counter and flash_req behaviour as above.
REQ-032 Without FINAL_COLOR_FLASH_EN: no FSM/counter logic; flash_req ignored; flash_active tied 0; latency is still 2.

Structure
REQ-033 Shared package final_color_pkg SHALL hold the flash state typedef (IDLE, FLASH), default screen dimensions, TRANSPARENT, BLANK_COLOR and BG_COLOR constants.
REQ-034 Priority selection SHALL be one combinational sub-module, layer_priority_sel, parametrised by N_LAYERS/COLOR_W/TRANSPARENT.

Verification
REQ-035 layers {L0=7,L1=2,L2=5,L3=7}, hPos=100, vPos=100 -> color=2 two cycles later, valid_out=1.
REQ-036 All layers=7 at (10,10) -> color=0; any layers at hPos=640 or vPos=480 -> color=7.
REQ-037 flash_req, then 8 frames of 4 pixels each -> frames 0,2,4,6 visible pixels = 4, odd frames = layer result; flash_active falls at the 8th boundary.
REQ-038 flash_req again during frame 5 -> counter restarts; 8 more frames of flash follow.
REQ-039 reset asserted during FLASH frame 3 -> next cycle flash_active=0, valid_out=0, color=7.
REQ-040 Build without FINAL_COLOR_FLASH_EN, pulse flash_req -> output identical to no-flash golden model; flash_active=0.
